// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and size/crossing helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StAcc0,
    StAcc1,
    StResp
  } lsu_state_t;

  // Byte mask for the access size, anchored at byte lane 0.
  function automatic logic [3:0] size_mask(input logic [2:0] ctrl);
    logic [3:0] mask;
    case (ctrl)
      DM_B, DM_BU: mask = 4'b0001;
      DM_H, DM_HU: mask = 4'b0011;
      DM_W:        mask = 4'b1111;
      default:     mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Unsigned variants only exist for loads.
  function automatic logic ctrl_legal(input logic [2:0] ctrl, input logic we);
    logic ok;
    case (ctrl)
      DM_B, DM_H, DM_W: ok = 1'b1;
      DM_BU, DM_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic crosses_word(input logic [2:0] ctrl, input logic [1:0] off);
    logic [7:0] span;
    span = {4'b0000, size_mask(ctrl)} << off;
    return |span[7:4];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane shifting over a two-word span and load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] r0_i,
  input  logic [31:0] r1_i,
  output logic [7:0]  be_span_o,
  output logic [63:0] wdata_span_o,
  output logic [31:0] load_data_o
);

  logic [4:0]  shamt;
  logic [31:0] rd_word;

  assign shamt = {off_i, 3'b000};

  always_comb begin
    be_span_o    = {4'b0000, size_mask(ctrl_i)} << off_i;
    wdata_span_o = {32'h0000_0000, wdata_i} << shamt;
    rd_word      = 32'({r1_i, r0_i} >> shamt);
    load_data_o  = '0;
    case (ctrl_i)
      DM_B:    load_data_o = {{24{rd_word[7]}}, rd_word[7:0]};
      DM_BU:   load_data_o = {24'h000000, rd_word[7:0]};
      DM_H:    load_data_o = {{16{rd_word[15]}}, rd_word[15:0]};
      DM_HU:   load_data_o = {16'h0000, rd_word[15:0]};
      DM_W:    load_data_o = rd_word;
      default: load_data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one request per transaction, word-crossing accesses split
// into two req/ack memory cycles, one-cycle response pulse with extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        dm_write,
  input  logic [2:0]  dm_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [1:0]  off_q, off_d;
  logic [29:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] r0_q, r0_d;
  logic [31:0] r1_q, r1_d;

  logic        req_illegal;
  logic [7:0]  be_span;
  logic [63:0] wdata_span;
  logic [31:0] load_data;

  assign req_illegal = !ctrl_legal(dm_ctrl, dm_write) ||
                       (!SPLIT_MISALIGNED && crosses_word(dm_ctrl, addr[1:0]));

  lsu_align u_align (
    .ctrl_i       (ctrl_q),
    .off_i        (off_q),
    .wdata_i      (wdata_q),
    .r0_i         (r0_q),
    .r1_i         (r1_q),
    .be_span_o    (be_span),
    .wdata_span_o (wdata_span),
    .load_data_o  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      ctrl_q  <= '0;
      off_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      ctrl_q  <= ctrl_d;
      off_q   <= off_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    err_d      = err_q;
    ctrl_d     = ctrl_q;
    off_d      = off_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    r0_d       = r0_q;
    r1_d       = r1_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    rdata      = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = dm_write;
          err_d   = req_illegal;
          ctrl_d  = dm_ctrl;
          off_d   = addr[1:0];
          word_d  = addr[31:2];
          wdata_d = wdata;
          r0_d    = '0;
          r1_d    = '0;
          state_d = req_illegal ? StResp : StAcc0;
        end
      end
      StAcc0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {word_q, 2'b00};
        mem_be    = be_span[3:0];
        mem_wdata = wdata_span[31:0];
        if (mem_ack) begin
          r0_d    = mem_rdata;
          state_d = (|be_span[7:4]) ? StAcc1 : StResp;
        end
      end
      StAcc1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        // 30-bit word index wraps 0xFFFFFFFC to 0x00000000.
        mem_addr  = {word_q + 30'd1, 2'b00};
        mem_be    = be_span[7:4];
        mem_wdata = wdata_span[63:32];
        if (mem_ack) begin
          r1_d    = mem_rdata;
          state_d = StResp;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        rdata      = (err_q || we_q) ? '0 : load_data;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with an inline memory responder.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        dm_write;
  logic [2:0]  dm_ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  load_store_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .dm_write   (dm_write),
    .dm_ctrl    (dm_ctrl),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one accepting edge.
  task automatic issue(input logic we, input logic [2:0] ctrl, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1;
    dm_write  = we;
    dm_ctrl   = ctrl;
    addr      = a;
    wdata     = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ack(input logic [31:0] d);
    mem_ack   = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; dm_write = 1'b0; dm_ctrl = '0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);

    // SW 0x100, immediate ack
    issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    chk("sw_req", {30'b0, mem_req, mem_we}, 32'd3);
    chk("sw_ready_busy", {31'b0, req_ready}, 32'd0);
    chk("sw_addr", mem_addr, 32'h0000_0100);
    chk("sw_be", {28'b0, mem_be}, 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    ack(32'h1234_5678);
    chk("sw_resp", {30'b0, resp_valid, resp_err}, 32'd2);
    chk("sw_rdata", rdata, 32'd0);
    chk("sw_req_drop", {31'b0, mem_req}, 32'd0);
    tick();
    chk("sw_idle", {30'b0, req_ready, resp_valid}, 32'd2);

    // LB / LBU at 0x103
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
    chk("lb_addr", mem_addr, 32'h0000_0100);
    chk("lb_be", {28'b0, mem_be}, 32'h8);
    chk("lb_we", {31'b0, mem_we}, 32'd0);
    ack(32'h80FF_FFFF);
    chk("lb_resp", {30'b0, resp_valid, resp_err}, 32'd2);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    tick();
    issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
    ack(32'h80FF_FFFF);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    tick();

    // LH / LHU at 0x102, aligned within the word
    issue(1'b0, 3'b001, 32'h0000_0102, 32'h0);
    chk("lh_be", {28'b0, mem_be}, 32'hC);
    ack(32'hF00D_1111);
    chk("lh_rdata", rdata, 32'hFFFF_F00D);
    tick();
    issue(1'b0, 3'b101, 32'h0000_0102, 32'h0);
    ack(32'hF00D_1111);
    chk("lhu_rdata", rdata, 32'h0000_F00D);
    tick();

    // Split LW at 0x102
    issue(1'b0, 3'b010, 32'h0000_0102, 32'h0);
    chk("lw2_addr0", mem_addr, 32'h0000_0100);
    chk("lw2_be0", {28'b0, mem_be}, 32'hC);
    ack(32'h4433_2211);
    chk("lw2_req1", {31'b0, mem_req}, 32'd1);
    chk("lw2_resp_early", {31'b0, resp_valid}, 32'd0);
    chk("lw2_addr1", mem_addr, 32'h0000_0104);
    chk("lw2_be1", {28'b0, mem_be}, 32'h3);
    ack(32'h8877_6655);
    chk("lw2_resp", {30'b0, resp_valid, resp_err}, 32'd2);
    chk("lw2_rdata", rdata, 32'h6655_4433);
    tick();

    // Split SH at 0x107
    issue(1'b1, 3'b001, 32'h0000_0107, 32'h0000_ABCD);
    chk("sh_addr0", mem_addr, 32'h0000_0104);
    chk("sh_be0", {28'b0, mem_be}, 32'h8);
    chk("sh_wdata0", mem_wdata, 32'hCD00_0000);
    ack(32'h0);
    chk("sh_addr1", mem_addr, 32'h0000_0108);
    chk("sh_be1", {28'b0, mem_be}, 32'h1);
    chk("sh_wdata1", mem_wdata, 32'h0000_00AB);
    chk("sh_we1", {31'b0, mem_we}, 32'd1);
    ack(32'h0);
    chk("sh_resp", {30'b0, resp_valid, resp_err}, 32'd2);
    chk("sh_rdata", rdata, 32'd0);
    tick();

    // LW at 0xFFFFFFFE wraps the second word to 0
    issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    ack(32'hBBAA_0000);
    chk("wrap_addr1", mem_addr, 32'h0000_0000);
    ack(32'h0000_DDCC);
    chk("wrap_rdata", rdata, 32'hDDCC_BBAA);
    tick();

    // Illegal ctrl and unsigned store: no memory cycle, error at accept+1
    issue(1'b0, 3'b011, 32'h0000_0100, 32'h0);
    chk("ill_req", {31'b0, mem_req}, 32'd0);
    chk("ill_resp", {30'b0, resp_valid, resp_err}, 32'd3);
    chk("ill_rdata", rdata, 32'd0);
    tick();
    chk("ill_idle", {30'b0, req_ready, mem_req}, 32'd2);
    issue(1'b1, 3'b101, 32'h0000_0100, 32'h1234);
    chk("ill_sthu", {29'b0, mem_req, resp_valid, resp_err}, 32'd3);
    tick();

    // Reset during a stalled LW, then a late ack
    issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
    chk("rstx_req", {31'b0, mem_req}, 32'd1);
    tick();
    chk("rstx_hold", mem_addr, 32'h0000_0200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstx_req_drop", {31'b0, mem_req}, 32'd0);
    chk("rstx_ready", {31'b0, req_ready}, 32'd1);
    tick();
    ack(32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      chk("rstx_quiet", {30'b0, resp_valid, mem_req}, 32'd0);
      tick();
    end

    // Unit still works afterwards
    issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
    ack(32'h0BAD_CAFE);
    chk("post_rdata", rdata, 32'h0BAD_CAFE);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
